// File: rtl/bank_command_sequencer.sv
// Per-bank DRAM command sequencer: one request in flight, open-page policy, periodic refresh, tRCD/tRP/tRAS/tRFC enforced.
// Commands are registered; req_ready only in IDLE with no refresh pending.
module bank_command_sequencer #(
  parameter int ROW_LSB = 13,
  parameter int ROW_W   = 16,
  parameter int T_RCD   = 14,
  parameter int T_RP    = 14,
  parameter int T_RAS   = 33,
  parameter int T_RFC   = 160,
  parameter int T_REFI  = 3900
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_is_write,
  input  logic [31:0] req_id,
  output logic        cmd_fire,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_cs,
  output logic        cmd_ras,
  output logic        cmd_cas,
  output logic        cmd_we,
  output logic [31:0] cmd_id
);

  localparam logic [16:0] RCD       = 17'(T_RCD);
  localparam logic [16:0] RP        = 17'(T_RP);
  localparam logic [16:0] RAS       = 17'(T_RAS);
  localparam logic [16:0] RFC       = 17'(T_RFC);
  localparam logic [15:0] REFI_LAST = 16'(T_REFI - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_COL, S_REF, S_WAIT_RFC
  } state_e;

  typedef enum logic [2:0] {K_NOP, K_REF, K_PRE, K_ACT, K_RD, K_WR} cmd_kind_e;

  state_e            state_q, state_d;
  logic              row_open_q, row_open_d;
  logic [ROW_W-1:0]  open_row_q, open_row_d;
  logic              ref_pending_q, ref_pending_d;
  logic [15:0]       timer_q, timer_d;
  logic [15:0]       tras_q, tras_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       id_q, id_d;
  logic              wr_q, wr_d;

  logic              fire_q, fire_d;
  logic [3:0]        enc_q, enc_d;
  logic [31:0]       caddr_q, caddr_d;
  logic [31:0]       cdata_q, cdata_d;
  logic [31:0]       cid_q, cid_d;

  logic [31:0]       src_addr, src_data, src_id;
  logic              src_wr;
  logic [ROW_W-1:0]  src_row;
  logic [16:0]       elapsed;
  logic              pre_ok;
  logic              wrap;
  cmd_kind_e         kind;
  cmd_kind_e         col_kind;

  // In IDLE the command is built from the incoming request, elsewhere from the latched copy.
  assign src_addr = (state_q == S_IDLE) ? req_addr     : addr_q;
  assign src_data = (state_q == S_IDLE) ? req_data     : data_q;
  assign src_id   = (state_q == S_IDLE) ? req_id       : id_q;
  assign src_wr   = (state_q == S_IDLE) ? req_is_write : wr_q;
  assign src_row  = src_addr[ROW_LSB +: ROW_W];
  assign col_kind = src_wr ? K_WR : K_RD;

  // Decisions made this cycle appear on the bus next cycle, hence the +1.
  assign elapsed   = {1'b0, cnt_q} + 17'd1;
  assign pre_ok    = ({1'b0, tras_q} + 17'd1) >= RAS;
  assign wrap      = (timer_q == REFI_LAST);
  assign req_ready = (state_q == S_IDLE) && !ref_pending_q;

  always_comb begin
    state_d    = state_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    data_d     = data_q;
    id_d       = id_q;
    wr_d       = wr_q;
    tras_d     = (tras_q == 16'hFFFF) ? tras_q : tras_q + 16'd1;
    cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    timer_d    = wrap ? 16'd0 : timer_q + 16'd1;
    kind       = K_NOP;

    case (state_q)
      S_IDLE: begin
        if (ref_pending_q) begin
          if (!row_open_q)  kind    = K_REF;
          else if (pre_ok)  kind    = K_PRE;
          else              state_d = S_PRE;
        end else if (req_valid) begin
          busy_d = 1'b1;
          addr_d = req_addr;
          data_d = req_data;
          id_d   = req_id;
          wr_d   = req_is_write;
          if (!row_open_q)                kind    = K_ACT;
          else if (src_row == open_row_q) kind    = col_kind;
          else if (pre_ok)                kind    = K_PRE;
          else                            state_d = S_PRE;
        end
      end
      S_PRE:      if (pre_ok) kind = K_PRE;
      // An in-flight request finishes before a pending refresh is served.
      S_WAIT_RP:  if (elapsed >= RP) kind = (ref_pending_q && !busy_q) ? K_REF : K_ACT;
      S_ACT: begin
        if (RCD <= 17'd1) kind = col_kind;
        else begin
          state_d = S_WAIT_RCD;
          cnt_d   = 16'd1;
        end
      end
      S_WAIT_RCD: if (elapsed >= RCD) kind = col_kind;
      S_COL: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      S_REF: begin
        if (RFC <= 17'd1) state_d = S_IDLE;
        else begin
          state_d = S_WAIT_RFC;
          cnt_d   = 16'd1;
        end
      end
      S_WAIT_RFC: if (elapsed >= RFC) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    case (kind)
      K_PRE: begin
        state_d    = S_WAIT_RP;
        cnt_d      = 16'd0;
        row_open_d = 1'b0;
      end
      K_ACT: begin
        state_d    = S_ACT;
        row_open_d = 1'b1;
        open_row_d = src_row;
        tras_d     = 16'd0;
      end
      K_RD, K_WR: state_d = S_COL;
      K_REF:      state_d = S_REF;
      default: ;
    endcase

    ref_pending_d = (ref_pending_q && (kind != K_REF)) || wrap;
  end

  always_comb begin
    fire_d  = 1'b0;
    enc_d   = 4'b1111;
    caddr_d = 32'd0;
    cdata_d = 32'd0;
    cid_d   = 32'd0;
    if (kind != K_NOP) begin
      fire_d = 1'b1;
      if (kind != K_REF) begin
        caddr_d = src_addr;
        cid_d   = src_id;
      end
    end
    case (kind)
      K_REF: enc_d = 4'b0001;
      K_PRE: enc_d = 4'b0010;
      K_ACT: enc_d = 4'b0011;
      K_RD:  enc_d = 4'b0101;
      K_WR: begin
        enc_d   = 4'b0100;
        cdata_d = src_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      row_open_q    <= 1'b0;
      open_row_q    <= '0;
      ref_pending_q <= 1'b0;
      timer_q       <= 16'd0;
      tras_q        <= 16'd0;
      cnt_q         <= 16'd0;
      busy_q        <= 1'b0;
      addr_q        <= 32'd0;
      data_q        <= 32'd0;
      id_q          <= 32'd0;
      wr_q          <= 1'b0;
      fire_q        <= 1'b0;
      enc_q         <= 4'b1111;
      caddr_q       <= 32'd0;
      cdata_q       <= 32'd0;
      cid_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      row_open_q    <= row_open_d;
      open_row_q    <= open_row_d;
      ref_pending_q <= ref_pending_d;
      timer_q       <= timer_d;
      tras_q        <= tras_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      id_q          <= id_d;
      wr_q          <= wr_d;
      fire_q        <= fire_d;
      enc_q         <= enc_d;
      caddr_q       <= caddr_d;
      cdata_q       <= cdata_d;
      cid_q         <= cid_d;
    end
  end

  assign cmd_fire = fire_q;
  assign cmd_cs   = enc_q[3];
  assign cmd_ras  = enc_q[2];
  assign cmd_cas  = enc_q[1];
  assign cmd_we   = enc_q[0];
  assign cmd_addr = caddr_q;
  assign cmd_data = cdata_q;
  assign cmd_id   = cid_q;

endmodule

// File: tb/tb_bank_command_sequencer.sv
// Directed bench for bank_command_sequencer with short timings; cycle numbers count from reset release.
module tb_bank_command_sequencer;

  localparam logic [3:0] E_NOP = 4'b1111;
  localparam logic [3:0] E_REF = 4'b0001;
  localparam logic [3:0] E_PRE = 4'b0010;
  localparam logic [3:0] E_ACT = 4'b0011;
  localparam logic [3:0] E_RD  = 4'b0101;
  localparam logic [3:0] E_WR  = 4'b0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_is_write;
  logic [31:0] req_id;
  logic        cmd_fire;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_cs, cmd_ras, cmd_cas, cmd_we;
  logic [31:0] cmd_id;

  int n_vec = 0;
  int n_bad = 0;
  int cyc;

  bank_command_sequencer #(
    .ROW_LSB(13), .ROW_W(16), .T_RCD(3), .T_RP(3), .T_RAS(6), .T_RFC(8), .T_REFI(100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_is_write(req_is_write), .req_id(req_id),
    .cmd_fire(cmd_fire), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_cs(cmd_cs), .cmd_ras(cmd_ras), .cmd_cas(cmd_cas), .cmd_we(cmd_we),
    .cmd_id(cmd_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic exp_enc(input string tag, input logic [3:0] enc);
    chk({tag, "/fire"}, 32'(cmd_fire), (enc != E_NOP) ? 32'd1 : 32'd0);
    chk({tag, "/enc"}, {28'd0, cmd_cs, cmd_ras, cmd_cas, cmd_we}, {28'd0, enc});
  endtask

  task automatic exp_cmd(input string tag, input logic [3:0] enc,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] id);
    exp_enc(tag, enc);
    chk({tag, "/addr"}, cmd_addr, a);
    chk({tag, "/data"}, cmd_data, d);
    chk({tag, "/id"}, cmd_id, id);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [31:0] id);
    req_valid    = v;
    req_addr     = a;
    req_data     = d;
    req_is_write = w;
    req_id       = id;
  endtask

  task automatic idle_req();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_req();
    repeat (3) @(negedge clk);
    exp_cmd("rst", E_NOP, 32'd0, 32'd0, 32'd0);
    chk("rst/ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;

    // Refresh on a closed, idle bank; a request waits through tRFC.
    wait_until(99);
    chk("t4/ready_pre_wrap", 32'(req_ready), 32'd1);
    wait_until(100);
    chk("t4/ready_pending", 32'(req_ready), 32'd0);
    exp_enc("t4/nop", E_NOP);
    wait_until(101);
    exp_cmd("t4/ref", E_REF, 32'd0, 32'd0, 32'd0);
    wait_until(105);
    drive(1'b1, 32'h0000_4000, 32'h0000_1234, 1'b0, 32'd7);
    wait_until(108);
    chk("t4/ready_rfc", 32'(req_ready), 32'd0);
    wait_until(109);
    chk("t4/ready_after_rfc", 32'(req_ready), 32'd1);

    // Closed-bank read accepted at 109.
    wait_until(110);
    idle_req();
    exp_cmd("t1/act", E_ACT, 32'h0000_4000, 32'd0, 32'd7);
    chk("t1/ready_busy", 32'(req_ready), 32'd0);
    wait_until(111);
    exp_cmd("t1/nop", E_NOP, 32'd0, 32'd0, 32'd0);
    wait_until(113);
    exp_cmd("t1/rd", E_RD, 32'h0000_4000, 32'd0, 32'd7);
    wait_until(114);
    chk("t1/ready_again", 32'(req_ready), 32'd1);

    // Row hit write accepted at 114.
    drive(1'b1, 32'h0000_4010, 32'h0000_A5A5, 1'b1, 32'd8);
    wait_until(115);
    idle_req();
    exp_cmd("t2/wr", E_WR, 32'h0000_4010, 32'h0000_A5A5, 32'd8);
    wait_until(116);
    chk("t2/ready", 32'(req_ready), 32'd1);

    // Row conflict with tRAS already met: PRE at accept+1.
    drive(1'b1, 32'h0000_8000, 32'h0000_DEAD, 1'b0, 32'd9);
    wait_until(117);
    idle_req();
    exp_cmd("t3a/pre", E_PRE, 32'h0000_8000, 32'd0, 32'd9);
    wait_until(118);
    exp_enc("t3a/nop", E_NOP);
    wait_until(120);
    exp_cmd("t3a/act", E_ACT, 32'h0000_8000, 32'd0, 32'd9);
    wait_until(123);
    exp_cmd("t3a/rd", E_RD, 32'h0000_8000, 32'd0, 32'd9);

    // Row conflict 4 cycles after ACT: PRE held until ACT+T_RAS.
    wait_until(124);
    drive(1'b1, 32'h0000_4000, 32'd0, 1'b0, 32'd10);
    wait_until(125);
    idle_req();
    exp_enc("t3b/tras_hold", E_NOP);
    wait_until(126);
    exp_cmd("t3b/pre", E_PRE, 32'h0000_4000, 32'd0, 32'd10);
    wait_until(129);
    exp_cmd("t3b/act", E_ACT, 32'h0000_4000, 32'd0, 32'd10);
    wait_until(132);
    exp_cmd("t3b/rd", E_RD, 32'h0000_4000, 32'd0, 32'd10);

    // Refresh beats a request on an open row; the request then needs ACT.
    wait_until(199);
    chk("t5/ready_pre_wrap", 32'(req_ready), 32'd1);
    wait_until(200);
    drive(1'b1, 32'h0000_4000, 32'd0, 1'b0, 32'd11);
    chk("t5/ready_pending", 32'(req_ready), 32'd0);
    exp_enc("t5/nop", E_NOP);
    wait_until(201);
    exp_enc("t5/pre", E_PRE);
    wait_until(202);
    exp_enc("t5/rp_wait", E_NOP);
    wait_until(204);
    exp_cmd("t5/ref", E_REF, 32'd0, 32'd0, 32'd0);
    wait_until(211);
    chk("t5/ready_rfc", 32'(req_ready), 32'd0);
    wait_until(212);
    chk("t5/ready_after_rfc", 32'(req_ready), 32'd1);
    wait_until(213);
    idle_req();
    exp_cmd("t5/act", E_ACT, 32'h0000_4000, 32'd0, 32'd11);
    wait_until(216);
    exp_cmd("t5/rd", E_RD, 32'h0000_4000, 32'd0, 32'd11);

    // Reset in the tRCD wait abandons the sequence.
    wait_until(217);
    drive(1'b1, 32'h0000_C000, 32'd0, 1'b0, 32'd12);
    wait_until(218);
    idle_req();
    wait_until(219);
    exp_cmd("t6/pre", E_PRE, 32'h0000_C000, 32'd0, 32'd12);
    wait_until(222);
    exp_cmd("t6/act", E_ACT, 32'h0000_C000, 32'd0, 32'd12);
    wait_until(223);
    chk("t6/ready_rcd", 32'(req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    exp_cmd("t6/async", E_NOP, 32'd0, 32'd0, 32'd0);
    chk("t6/ready_async", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      exp_enc("t6/in_rst", E_NOP);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_until(k);
      exp_enc("t6/post_rst", E_NOP);
    end
    drive(1'b1, 32'h0000_C000, 32'd0, 1'b0, 32'd12);
    wait_until(3);
    idle_req();
    exp_cmd("t6/act_again", E_ACT, 32'h0000_C000, 32'd0, 32'd12);
    wait_until(6);
    exp_cmd("t6/rd_again", E_RD, 32'h0000_C000, 32'd0, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
